// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared types and defaults for the PLL lock supervisor
package pll_sup_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK  = 2'd0,
    ST_STABILIZE  = 2'd1,
    ST_HOLD_RESET = 2'd2,
    ST_RUN        = 2'd3
  } sup_state_t;

  localparam int DEF_SYNC_STAGES        = 2;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_RESET_HOLD_CYCLES  = 16;
  localparam int STAT_W                 = 8;

  // Width that holds the larger of the two stage lengths without wrapping.
  function automatic int stage_cnt_w(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop single-bit synchronizer, resets to 0
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - sequences downstream reset release from PLL lock
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              locked,
  input  logic              clear_stats,
  output logic              sys_reset_n,
  output logic              ready,
  output logic [STAT_W-1:0] lock_lost_count,
  output logic              lock_lost_sticky
);

  localparam int CNT_W = stage_cnt_w(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);

  logic       lock_s;
  sup_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       loss_event;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clock_in),
    .rst_n(reset_n),
    .d    (locked),
    .q    (lock_s)
  );

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_WAIT_LOCK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    loss_event = 1'b0;
    case (state_q)
      ST_WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) begin
          state_d = ST_STABILIZE;
        end
      end
      ST_STABILIZE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ST_HOLD_RESET;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD_RESET: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d    = ST_WAIT_LOCK;
          loss_event = 1'b1;
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are flopped from the next state so they track the state register exactly.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
    end else begin
      sys_reset_n <= (state_d == ST_RUN);
      ready       <= (state_d == ST_RUN);
    end
  end

  // A loss on the same edge as a clear counts as the first event after the clear.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      lock_lost_count  <= '0;
      lock_lost_sticky <= 1'b0;
    end else if (clear_stats) begin
      lock_lost_count  <= loss_event ? STAT_W'(1) : '0;
      lock_lost_sticky <= loss_event;
    end else if (loss_event) begin
      lock_lost_sticky <= 1'b1;
      if (lock_lost_count != '1) begin
        lock_lost_count <= lock_lost_count + 1'b1;
      end
    end
  end

endmodule
